lif_timestep_scheduler: RTL and testbench

//  Time-multiplexes one Q8.8 LIF update datapath across N_NEURONS virtual neurons.
//  On each timestep it walks neuron indices 0..N-1 in order, one update per accepted input.

---
 rtl/lif_timestep_scheduler.sv | 200 ++++++++++++++++++++
 tb/tb_lif_timestep_scheduler.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/lif_timestep_scheduler.sv
// Time-multiplexed Q8.8 LIF neuron scheduler that emits spike events through a small FIFO.
// Defining LIF_REFRACTORY_EN builds the per-neuron refractory counters.
module lif_timestep_scheduler #(
   parameter int unsigned N_NEURONS  = 16,
   parameter logic [15:0] THRESH     = 16'd256,
   parameter logic [15:0] ALPHA      = 16'd240,
   parameter logic [15:0] BETA       = 16'd16,
   parameter int unsigned FIFO_DEPTH = 4,
   parameter int unsigned REFRAC     = 2,
   localparam int unsigned IDX_W     = $clog2(N_NEURONS)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             step_start,
   output logic             busy,
   output logic             step_done,
   input  logic             cur_valid,
   output logic             cur_ready,
   input  logic [15:0]      cur_data,
   output logic [IDX_W-1:0] cur_idx,
   output logic             spk_valid,
   input  logic             spk_ready,
   output logic [IDX_W-1:0] spk_id,
   input  logic [IDX_W-1:0] mon_idx,
   output logic [15:0]      mon_v
);

   localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
   localparam int unsigned CNT_W = PTR_W + 1;

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_RUN   = 2'd1,
      S_DRAIN = 2'd2,
      S_DONE  = 2'd3
   } state_t;

   state_t           state_q, state_d;
   logic [IDX_W-1:0] idx_q, idx_d;
   logic [15:0]      v_q [N_NEURONS];
   logic [15:0]      v_d [N_NEURONS];
   logic [IDX_W-1:0] fifo_q [FIFO_DEPTH];
   logic [IDX_W-1:0] fifo_d [FIFO_DEPTH];
   logic [PTR_W-1:0] wr_q, wr_d, rd_q, rd_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             busy_q, busy_d, done_q, done_d;
   logic             fifo_full_s, fifo_empty_s, xfer_s, push_s, pop_s, fire_s, hold_s;
   logic [31:0]      sum_s;
   logic [15:0]      vn_s;
   logic             unused_frac_s;

   assign fifo_full_s  = (cnt_q == CNT_W'(FIFO_DEPTH));
   assign fifo_empty_s = (cnt_q == {CNT_W{1'b0}});
   assign cur_ready    = (state_q == S_RUN) && !fifo_full_s;
   assign xfer_s       = cur_valid && cur_ready;
   assign fire_s       = xfer_s && !hold_s && (vn_s >= THRESH);
   assign push_s       = fire_s;
   assign pop_s        = spk_ready && !fifo_empty_s;

   assign busy      = busy_q;
   assign step_done = done_q;
   assign cur_idx   = idx_q;
   assign spk_valid = !fifo_empty_s;
   assign spk_id    = fifo_q[rd_q];
   assign mon_v     = (32'(mon_idx) < N_NEURONS) ? v_q[mon_idx] : 16'h0000;
   assign unused_frac_s = ^sum_s[7:0];

   // Leak/integrate datapath for the neuron currently addressed by idx_q.
   always_comb begin
      sum_s = ({16'h0000, v_q[idx_q]} * {16'h0000, ALPHA})
            + ({16'h0000, cur_data} * {16'h0000, BETA});
      if (sum_s[31:24] != 8'h00) begin
         vn_s = 16'hFFFF;
      end else begin
         vn_s = sum_s[23:8];
      end
   end

`ifdef LIF_REFRACTORY_EN
   localparam int unsigned RF_W = (REFRAC < 2) ? 1 : $clog2(REFRAC + 1);
   logic [RF_W-1:0] rf_q [N_NEURONS];
   logic [RF_W-1:0] rf_d [N_NEURONS];

   assign hold_s = (rf_q[idx_q] != {RF_W{1'b0}});

   // Refractory counter: armed on a spike, counts down on each update while held.
   always_comb begin
      rf_d = rf_q;
      if (xfer_s) begin
         if (hold_s) begin
            rf_d[idx_q] = rf_q[idx_q] - RF_W'(1);
         end else if (fire_s) begin
            rf_d[idx_q] = RF_W'(REFRAC);
         end else begin
            rf_d[idx_q] = rf_q[idx_q];
         end
      end else begin
         rf_d[idx_q] = rf_q[idx_q];
      end
   end

   // Refractory counter registers.
   always_ff @(posedge clk) begin
      if (rst) begin
         rf_q <= '{default: {RF_W{1'b0}}};
      end else begin
         rf_q <= rf_d;
      end
   end
`else
   localparam int unsigned unused_refrac_p = REFRAC;
   assign hold_s = 1'b0;
`endif

   // Timestep sequencing and membrane write-back.
   always_comb begin
      state_d = state_q;
      idx_d   = idx_q;
      v_d     = v_q;
      case (state_q)
         S_IDLE: begin
            if (step_start) state_d = S_RUN;
            else            state_d = S_IDLE;
         end
         S_RUN: begin
            if (xfer_s) begin
               if (idx_q == IDX_W'(N_NEURONS - 1)) begin
                  idx_d   = {IDX_W{1'b0}};
                  state_d = S_DRAIN;
               end else begin
                  idx_d = idx_q + IDX_W'(1);
               end
            end else begin
               state_d = S_RUN;
            end
         end
         S_DRAIN: begin
            if (fifo_empty_s) state_d = S_DONE;
            else              state_d = S_DRAIN;
         end
         S_DONE:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
      // A firing (or refractory) neuron resets to zero instead of keeping Vn.
      if (xfer_s) begin
         if (hold_s || fire_s) v_d[idx_q] = 16'h0000;
         else                  v_d[idx_q] = vn_s;
      end else begin
         v_d[idx_q] = v_q[idx_q];
      end
      busy_d = (state_d != S_IDLE);
      done_d = (state_d == S_DONE);
   end

   // Spike FIFO bookkeeping; a pop and a push may share one cycle.
   always_comb begin
      fifo_d = fifo_q;
      wr_d   = wr_q;
      rd_d   = rd_q;
      if (push_s) begin
         fifo_d[wr_q] = idx_q;
         wr_d         = wr_q + PTR_W'(1);
      end else begin
         wr_d = wr_q;
      end
      if (pop_s) rd_d = rd_q + PTR_W'(1);
      else       rd_d = rd_q;
      case ({push_s, pop_s})
         2'b10:   cnt_d = cnt_q + CNT_W'(1);
         2'b01:   cnt_d = cnt_q - CNT_W'(1);
         default: cnt_d = cnt_q;
      endcase
   end

   // State, membrane and FIFO registers.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= S_IDLE;
         idx_q   <= {IDX_W{1'b0}};
         v_q     <= '{default: 16'h0000};
         fifo_q  <= '{default: {IDX_W{1'b0}}};
         wr_q    <= {PTR_W{1'b0}};
         rd_q    <= {PTR_W{1'b0}};
         cnt_q   <= {CNT_W{1'b0}};
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         idx_q   <= idx_d;
         v_q     <= v_d;
         fifo_q  <= fifo_d;
         wr_q    <= wr_d;
         rd_q    <= rd_d;
         cnt_q   <= cnt_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
      end
   end

endmodule

// File: tb/tb_lif_timestep_scheduler.sv
// Self-checking bench for lif_timestep_scheduler against an arithmetic LIF reference model.
module tb_lif_timestep_scheduler;

   localparam int NN = 8;
   localparam int IW = 3;
   localparam int RF = 2;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          step_start = 1'b0;
   logic          busy, step_done, cur_ready, spk_valid;
   logic          cur_valid = 1'b0;
   logic [15:0]   cur_data = 16'h0000;
   logic [IW-1:0] cur_idx, spk_id;
   logic          spk_ready = 1'b0;
   logic [IW-1:0] mon_idx = '0;
   logic [15:0]   mon_v;

   int n_checks = 0;
   int n_fail   = 0;
   int done_cnt = 0;
   int got_q[$];
   int exp_q[$];
   int unsigned mv [NN];
   int rfc [NN];
   bit fired0;

   lif_timestep_scheduler #(
      .N_NEURONS(NN), .THRESH(16'd256), .ALPHA(16'd240), .BETA(16'd16),
      .FIFO_DEPTH(4), .REFRAC(RF)
   ) dut (
      .clk(clk), .rst(rst), .step_start(step_start), .busy(busy), .step_done(step_done),
      .cur_valid(cur_valid), .cur_ready(cur_ready), .cur_data(cur_data), .cur_idx(cur_idx),
      .spk_valid(spk_valid), .spk_ready(spk_ready), .spk_id(spk_id),
      .mon_idx(mon_idx), .mon_v(mon_v)
   );

   always #20 clk = ~clk;

   // Spike and step_done observation mid-cycle, where every signal is stable.
   always @(negedge clk) begin
      if (!rst && spk_valid && spk_ready) got_q.push_back(int'(spk_id));
      if (!rst && step_done) done_cnt++;
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      n_checks++;
      assert (obs === expv) else begin
         n_fail++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   function automatic void model_clear();
      for (int i = 0; i < NN; i++) begin
         mv[i]  = 0;
         rfc[i] = 0;
      end
      exp_q.delete();
   endfunction

   // Reference update: V' = min((V*0.9375 + I*0.0625) in Q8.8, 0xFFFF); fire at >= 1.0.
   function automatic void model_update(input int n, input int unsigned cur);
      int unsigned s;
      s = (mv[n] * 240 + cur * 16) / 256;
      if (s > 65535) s = 65535;
`ifdef LIF_REFRACTORY_EN
      if (rfc[n] > 0) begin
         rfc[n]--;
         mv[n] = 0;
         return;
      end
`endif
      if (s >= 256) begin
         mv[n]  = 0;
         rfc[n] = RF;
         exp_q.push_back(n);
      end else begin
         mv[n] = s;
      end
   endfunction

   task automatic reset_dut();
      rst = 1'b1; step_start = 1'b0; cur_valid = 1'b0; spk_ready = 1'b0;
      tick(); tick();
      rst = 1'b0;
      model_clear();
      got_q.delete();
   endtask

   task automatic check_mon(input string tag);
      for (int i = 0; i < NN; i++) begin
         mon_idx = IW'(i);
         #1;
         check(tag, 32'(mon_v), mv[i]);
      end
   endtask

   task automatic wait_done(input int done_before);
      int n = 0;
      spk_ready = 1'b1;
      while (step_done !== 1'b1 && n < 200) begin
         tick();
         n++;
      end
      check("step_done_seen", 32'(step_done), 32'd1);
      check("fifo_empty_at_done", 32'(spk_valid), 32'd0);
      tick();
      check("one_done_pulse", done_cnt, done_before + 1);
      check("idle_after_done", 32'(busy), 32'd0);
      check("spk_count", got_q.size(), exp_q.size());
      for (int i = 0; i < exp_q.size() && i < got_q.size(); i++)
         check("spk_order", got_q[i], exp_q[i]);
      fired0 = 1'b0;
      foreach (got_q[i]) if (got_q[i] == 0) fired0 = 1'b1;
      got_q.delete();
      exp_q.delete();
   endtask

   // One timestep: dmode 1 = random current, rmode 1 = random spk_ready after 'hold' stall cycles.
   task automatic do_step(input bit dmode, input logic [15:0] fixed, input bit tog,
                          input bit rmode, input int hold, input bit stall_chk, input bit restart);
      int k = 0;
      int cyc = 0;
      int d0;
      d0 = done_cnt;
      step_start = 1'b1;
      tick();
      step_start = 1'b0;
      check("busy_after_start", 32'(busy), 32'd1);
      while (k < NN && cyc < 500) begin
         cur_valid  = tog ? ~cyc[0] : 1'b1;
         cur_data   = dmode ? 16'($urandom_range(0, 1023)) : fixed;
         spk_ready  = (cyc < hold) ? 1'b0 : (rmode ? 1'($urandom_range(0, 1)) : 1'b1);
         step_start = restart && (cyc == 1);
         check("cur_idx", 32'(cur_idx), k);
         if (stall_chk && cyc == 8) begin
            check("stall_cur_ready", 32'(cur_ready), 32'd0);
            check("stall_cur_idx", 32'(cur_idx), 32'd4);
         end
         if (cur_valid && cur_ready) begin
            model_update(k, 32'(cur_data));
            k++;
         end
         tick();
         cyc++;
      end
      cur_valid  = 1'b0;
      step_start = 1'b0;
      check("all_neurons_updated", k, NN);
      wait_done(d0);
   endtask

   initial begin
      int d0;
      reset_dut();
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_step_done", 32'(step_done), 32'd0);
      check("rst_cur_ready", 32'(cur_ready), 32'd0);
      check("rst_spk_valid", 32'(spk_valid), 32'd0);
      check("rst_spk_id", 32'(spk_id), 32'd0);
      check("rst_cur_idx", 32'(cur_idx), 32'd0);
      check_mon("rst_mon_v");

      // Strong constant input, free-flowing output.
      for (int s = 0; s < 3; s++) begin
         do_step(1'b0, 16'h1000, 1'b0, 1'b0, 0, 1'b0, 1'b0);
         check_mon("s1_mon_v");
      end

      // Half-strength input integrates over two steps and fires on the third.
      reset_dut();
      do_step(1'b0, 16'h0800, 1'b0, 1'b0, 0, 1'b0, 1'b0);
      mon_idx = '0; #1; check("s2_v_step1", 32'(mon_v), 32'd128);
      do_step(1'b0, 16'h0800, 1'b0, 1'b0, 0, 1'b0, 1'b0);
      mon_idx = '0; #1; check("s2_v_step2", 32'(mon_v), 32'd248);
      do_step(1'b0, 16'h0800, 1'b0, 1'b0, 0, 1'b0, 1'b0);
      mon_idx = '0; #1; check("s2_v_step3", 32'(mon_v), 32'd0);
      check_mon("s2_mon_v");

      // Downstream back-pressure fills the FIFO and stalls the update stream.
      reset_dut();
      do_step(1'b0, 16'h1000, 1'b0, 1'b0, 10, 1'b1, 1'b0);
      check_mon("s3_mon_v");

      // Random currents, gappy cur_valid, random spk_ready, stray step_start while busy.
      reset_dut();
      for (int s = 0; s < 6; s++) begin
         do_step(1'b1, 16'h0000, 1'b1, 1'b1, 0, 1'b0, (s == 2));
         check_mon("s4_mon_v");
      end
      for (int s = 0; s < 4; s++) begin
         do_step(1'b1, 16'h0000, 1'b0, 1'b1, 3, 1'b0, 1'b0);
         check_mon("s4b_mon_v");
      end

      // Reset in the middle of RUN aborts the step without a done pulse.
      step_start = 1'b1; tick(); step_start = 1'b0;
      cur_valid = 1'b1; cur_data = 16'h0800; spk_ready = 1'b1;
      for (int i = 0; i < 2; i++) begin
         if (cur_ready) model_update(i, 32'(cur_data));
         tick();
      end
      check("s5_cur_idx_before_rst", 32'(cur_idx), 32'd2);
      d0 = done_cnt;
      rst = 1'b1; cur_valid = 1'b0;
      tick();
      rst = 1'b0;
      model_clear();
      got_q.delete();
      check("s5_busy", 32'(busy), 32'd0);
      check("s5_spk_valid", 32'(spk_valid), 32'd0);
      check("s5_cur_ready", 32'(cur_ready), 32'd0);
      check("s5_cur_idx", 32'(cur_idx), 32'd0);
      check_mon("s5_mon_v");
      tick(); tick(); tick();
      check("s5_no_done", done_cnt, d0);
      check("s5_still_idle", 32'(busy), 32'd0);

`ifdef LIF_REFRACTORY_EN
      // Refractory: neuron 0 fires on steps 1, 4, 7 and rests in between.
      reset_dut();
      for (int s = 1; s <= 7; s++) begin
         do_step(1'b0, 16'h1000, 1'b0, 1'b0, 0, 1'b0, 1'b0);
         check("s6_refrac_fire", 32'(fired0), 32'((s % 3) == 1));
         check_mon("s6_mon_v");
      end
`endif

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
